// File: rtl/rf_port_arbiter.sv
// Two-requester arbiter for the crypto core's single-ported 16x8 register file, with bounded
// burst locking for key loads and write protection of key registers against requester 1.
module rf_port_arbiter #(
  parameter int unsigned        DW           = 8,
  parameter int unsigned        AW           = 4,
  parameter logic [(2**AW)-1:0] PROTECT_MASK = 16'h000C,
  parameter int unsigned        MAX_LOCK     = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic          req0_lock,
  input  logic [AW-1:0] req0_rs1,
  input  logic [AW-1:0] req0_rs2,
  input  logic [AW-1:0] req0_rd,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata1,
  output logic [DW-1:0] rsp0_rdata2,
  output logic          rsp0_err,

  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic          req1_lock,
  input  logic [AW-1:0] req1_rs1,
  input  logic [AW-1:0] req1_rs2,
  input  logic [AW-1:0] req1_rd,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata1,
  output logic [DW-1:0] rsp1_rdata2,
  output logic          rsp1_err,

  output logic          rf_reg_write,
  output logic [AW-1:0] rf_rs1,
  output logic [AW-1:0] rf_rs2,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_write_data,
  input  logic [DW-1:0] rf_out_rs1,
  input  logic [DW-1:0] rf_out_rs2,

  output logic          last_grant
);

  localparam int unsigned CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_LOCK);

  typedef enum logic {StUnlocked, StLocked} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          last_grant_q, last_grant_d;

  logic          rsp0_valid_q, rsp1_valid_q, rsp0_err_q, rsp1_err_q;
  logic [DW-1:0] rsp0_rdata1_q, rsp0_rdata2_q, rsp1_rdata1_q, rsp1_rdata2_q;

  logic          owner_valid, hold, grant, winner, blocked;
  logic          win_we, win_lock;
  logic [AW-1:0] win_rs1, win_rs2, win_rd;
  logic [DW-1:0] win_wdata;
  logic [CW-1:0] cnt_inc;

  assign owner_valid = owner_q ? req1_valid : req0_valid;
  assign hold        = (state_q == StLocked) && owner_valid;
  assign cnt_inc     = lock_cnt_q + CW'(1);

  // A locked owner that drops valid falls straight through to round-robin in the same cycle.
  always_comb begin
    grant  = 1'b0;
    winner = 1'b0;
    if (hold) begin
      grant  = 1'b1;
      winner = owner_q;
    end else if (req0_valid && req1_valid) begin
      grant  = 1'b1;
      winner = ~last_grant_q;
    end else if (req0_valid) begin
      grant  = 1'b1;
      winner = 1'b0;
    end else if (req1_valid) begin
      grant  = 1'b1;
      winner = 1'b1;
    end
    if (reset) begin
      grant = 1'b0;
    end
  end

  assign win_we    = winner ? req1_we    : req0_we;
  assign win_lock  = winner ? req1_lock  : req0_lock;
  assign win_rs1   = winner ? req1_rs1   : req0_rs1;
  assign win_rs2   = winner ? req1_rs2   : req0_rs2;
  assign win_rd    = winner ? req1_rd    : req0_rd;
  assign win_wdata = winner ? req1_wdata : req0_wdata;

  assign blocked       = grant && winner && win_we && PROTECT_MASK[win_rd];
  assign rf_reg_write  = grant && win_we && !blocked;
  assign rf_rs1        = grant ? win_rs1   : '0;
  assign rf_rs2        = grant ? win_rs2   : '0;
  assign rf_rd         = grant ? win_rd    : '0;
  assign rf_write_data = grant ? win_wdata : '0;
  assign req0_ready    = grant && !winner;
  assign req1_ready    = grant && winner;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lock_cnt_d   = lock_cnt_q;
    last_grant_d = last_grant_q;
    if ((state_q == StLocked) && !owner_valid) begin
      state_d    = StUnlocked;
      lock_cnt_d = '0;
    end
    if (grant) begin
      last_grant_d = winner;
      if (hold) begin
        if (win_lock && (cnt_inc < MaxCnt)) begin
          lock_cnt_d = cnt_inc;
        end else begin
          state_d    = StUnlocked;
          lock_cnt_d = '0;
        end
      end else if (win_lock && (MaxCnt > CW'(1))) begin
        state_d    = StLocked;
        owner_d    = winner;
        lock_cnt_d = CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StUnlocked;
      owner_q      <= 1'b0;
      lock_cnt_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lock_cnt_q   <= lock_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Read data is the pre-write register value since read and write share the grant cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_valid_q  <= 1'b0;
      rsp0_rdata1_q <= '0;
      rsp0_rdata2_q <= '0;
      rsp0_err_q    <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_rdata1_q <= '0;
      rsp1_rdata2_q <= '0;
      rsp1_err_q    <= 1'b0;
    end else begin
      rsp0_valid_q <= grant && !winner;
      rsp1_valid_q <= grant && winner;
      if (grant && !winner) begin
        rsp0_rdata1_q <= rf_out_rs1;
        rsp0_rdata2_q <= rf_out_rs2;
        rsp0_err_q    <= blocked;
      end
      if (grant && winner) begin
        rsp1_rdata1_q <= rf_out_rs1;
        rsp1_rdata2_q <= rf_out_rs2;
        rsp1_err_q    <= blocked;
      end
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_rdata1 = rsp0_rdata1_q;
  assign rsp0_rdata2 = rsp0_rdata2_q;
  assign rsp0_err    = rsp0_err_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_rdata1 = rsp1_rdata1_q;
  assign rsp1_rdata2 = rsp1_rdata2_q;
  assign rsp1_err    = rsp1_err_q;
  assign last_grant  = last_grant_q;

endmodule
